// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count/width, floor and direction
// encodings, scheduler state encoding and small floor helpers.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 5;
    localparam int unsigned FLOOR_W    = 3;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam floor_t FLOOR_S = 3'd0;
    localparam floor_t FLOOR_1 = 3'd1;
    localparam floor_t FLOOR_2 = 3'd2;
    localparam floor_t FLOOR_3 = 3'd3;
    localparam floor_t FLOOR_4 = 3'd4;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_SERVE  = 2'b10
    } sched_state_t;

    // A floor index is only meaningful below NUM_FLOORS.
    function automatic logic floor_is_valid(input floor_t f);
        return f < floor_t'(NUM_FLOORS);
    endfunction

    // One-hot request mask for a floor; empty for an invalid index.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (f == floor_t'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_picker.sv
// Combinational SCAN helper: nearest pending floor strictly above and
// strictly below the current floor, each with a found flag.
module scan_picker
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    above_floor,
    output logic                  below_found,
    output logic [FLOOR_W-1:0]    below_floor
);

    // Ascending scan: first hit above is nearest above, last hit below is nearest below.
    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && (floor_t'(f) > cur_floor) && !above_found) begin
                above_found = 1'b1;
                above_floor = floor_t'(f);
            end
            if (pending[f] && (floor_t'(f) < cur_floor)) begin
                below_found = 1'b1;
                below_floor = floor_t'(f);
            end
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// Floor request scheduler: latches call requests, picks the next target
// with SCAN ordering, retargets to closer stops en route and clears a
// request when the car arrives at its target.
module floor_request_scheduler
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req_in,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [1:0]            dir,
    output logic [NUM_FLOORS-1:0] pending
);

    sched_state_t          state;
    dir_t                  dir_r;

    logic                  cur_valid;
    logic                  arrive_hit;
    logic [NUM_FLOORS-1:0] clear_mask;

    logic                  above_found;
    logic [FLOOR_W-1:0]    above_floor;
    logic                  below_found;
    logic [FLOOR_W-1:0]    below_floor;

    floor_t                pick_floor;
    dir_t                  pick_dir;
    floor_t                dist_up;
    floor_t                dist_dn;

    logic                  retarget_hit;
    floor_t                retarget_floor;

    assign dir       = dir_r;
    assign cur_valid = floor_is_valid(cur_floor);

    scan_picker u_scan_picker (
        .pending     (pending),
        .cur_floor   (cur_floor),
        .above_found (above_found),
        .above_floor (above_floor),
        .below_found (below_found),
        .below_floor (below_floor)
    );

    // Arrival counts only in SERVE at the current target; it frees that request.
    always_comb begin
        arrive_hit = (state == ST_SERVE) && arrived && (cur_floor == target_floor);
        clear_mask = '0;
        if (arrive_hit) begin
            clear_mask = floor_onehot(target_floor);
        end
    end

    // Request latch: new pulses set bits, an arrival clear overrides a same-cycle set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | req_in) & ~clear_mask;
        end
    end

    // SCAN pick: keep travelling direction if possible, else reverse; from idle nearest wins, ties go up.
    always_comb begin
        pick_floor = cur_floor;
        pick_dir   = dir_r;
        dist_up    = above_floor - cur_floor;
        dist_dn    = cur_floor - below_floor;
        case (dir_r)
            DIR_UP: begin
                if (above_found) begin
                    pick_floor = above_floor;
                end else if (below_found) begin
                    pick_floor = below_floor;
                    pick_dir   = DIR_DOWN;
                end
            end
            DIR_DOWN: begin
                if (below_found) begin
                    pick_floor = below_floor;
                end else if (above_found) begin
                    pick_floor = above_floor;
                    pick_dir   = DIR_UP;
                end
            end
            default: begin
                if (above_found && (!below_found || (dist_up <= dist_dn))) begin
                    pick_floor = above_floor;
                    pick_dir   = DIR_UP;
                end else if (below_found) begin
                    pick_floor = below_floor;
                    pick_dir   = DIR_DOWN;
                end
            end
        endcase
    end

    // Retarget when a pending floor lies strictly between the car and its target.
    always_comb begin
        retarget_hit   = 1'b0;
        retarget_floor = target_floor;
        if (cur_valid) begin
            if ((dir_r == DIR_UP) && above_found && (above_floor < target_floor)) begin
                retarget_hit   = 1'b1;
                retarget_floor = above_floor;
            end else if ((dir_r == DIR_DOWN) && below_found && (below_floor > target_floor)) begin
                retarget_hit   = 1'b1;
                retarget_floor = below_floor;
            end
        end
    end

    // Scheduler FSM with registered target/direction outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            target_valid <= 1'b0;
            target_floor <= FLOOR_S;
            dir_r        <= DIR_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    target_valid <= 1'b0;
                    dir_r        <= DIR_IDLE;
                    if (pending != '0) begin
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (cur_valid) begin
                        if (pending == '0) begin
                            state        <= ST_IDLE;
                            dir_r        <= DIR_IDLE;
                            target_valid <= 1'b0;
                        end else begin
                            state        <= ST_SERVE;
                            target_floor <= pick_floor;
                            dir_r        <= pick_dir;
                            target_valid <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    if (arrive_hit) begin
                        state        <= ST_SELECT;
                        target_valid <= 1'b0;
                    end else if (retarget_hit) begin
                        target_floor <= retarget_floor;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    target_valid <= 1'b0;
                    dir_r        <= DIR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: vector table, directed corner
// sequences and random traffic against a distance-based reference model.
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req_in;
    logic [2:0] cur_floor;
    logic       arrived;
    logic       target_valid;
    logic [2:0] target_floor;
    logic [1:0] dir;
    logic [4:0] pending;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: 0 idle, 1 select, 2 serve; dir 0 idle, 1 up, 2 down.
    int         m_state;
    logic [4:0] m_pend;
    logic       m_tv;
    int         m_tf;
    int         m_dir;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [2:0] cur;
        logic       arr;
        logic       tv;
        logic [2:0] tf;
        logic [1:0] dir;
        logic [4:0] pend;
    } vec_t;

    vec_t vecs[17];

    floor_request_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_in       (req_in),
        .cur_floor    (cur_floor),
        .arrived      (arrived),
        .target_valid (target_valid),
        .target_floor (target_floor),
        .dir          (dir),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, input logic [4:0] rq, input logic [2:0] cf,
                                input logic ar, input logic tv, input logic [2:0] tf,
                                input logic [1:0] d, input logic [4:0] p);
        vec_t v;
        v.rst = rs; v.req = rq; v.cur = cf; v.arr = ar;
        v.tv = tv; v.tf = tf; v.dir = d; v.pend = p;
        return v;
    endfunction

    // Scheduler rules as distances: nearest in travel direction, else reverse; ties go up.
    task automatic model_step(input logic [4:0] rq, input int cur, input logic ar, input logic rs);
        logic [4:0] np;
        int up_d;
        int dn_d;
        int best;
        if (!rs) begin
            m_state = 0; m_pend = '0; m_tv = 1'b0; m_tf = 0; m_dir = 0;
            return;
        end
        np = m_pend | rq;
        case (m_state)
            0: begin
                m_tv = 1'b0; m_dir = 0;
                if (m_pend != 0) m_state = 1;
            end
            1: begin
                if (cur < 5) begin
                    if (m_pend == 0) begin
                        m_state = 0; m_dir = 0; m_tv = 1'b0;
                    end else begin
                        up_d = 99; dn_d = 99;
                        for (int f = 0; f < 5; f++) begin
                            if (m_pend[f]) begin
                                if (f > cur && f - cur < up_d) up_d = f - cur;
                                if (f < cur && cur - f < dn_d) dn_d = cur - f;
                            end
                        end
                        m_tf = cur;
                        if (m_dir == 1) begin
                            if (up_d < 99) m_tf = cur + up_d;
                            else if (dn_d < 99) begin m_tf = cur - dn_d; m_dir = 2; end
                        end else if (m_dir == 2) begin
                            if (dn_d < 99) m_tf = cur - dn_d;
                            else if (up_d < 99) begin m_tf = cur + up_d; m_dir = 1; end
                        end else begin
                            if (up_d < 99 && up_d <= dn_d) begin m_tf = cur + up_d; m_dir = 1; end
                            else if (dn_d < 99) begin m_tf = cur - dn_d; m_dir = 2; end
                        end
                        m_tv = 1'b1; m_state = 2;
                    end
                end
            end
            default: begin
                if (ar && cur == m_tf) begin
                    np[m_tf] = 1'b0; m_tv = 1'b0; m_state = 1;
                end else if (cur < 5) begin
                    best = -1;
                    for (int f = 0; f < 5; f++) begin
                        if (m_pend[f] && ((m_dir == 1 && f > cur && f < m_tf) ||
                                          (m_dir == 2 && f < cur && f > m_tf))) begin
                            if (best < 0 || (f > best ? f - cur : cur - f) < (best > cur ? best - cur : cur - best))
                                best = f;
                        end
                    end
                    if (best >= 0) m_tf = best;
                end
            end
        endcase
        m_pend = np;
    endtask

    task automatic apply(input logic [4:0] rq, input logic [2:0] cf, input logic ar, input logic rs);
        req_in = rq; cur_floor = cf; arrived = ar; reset = rs;
        @(posedge clk);
        model_step(rq, int'(cf), ar, rs);
        #1;
    endtask

    task automatic check(input string nm, input logic etv, input logic [2:0] etf,
                         input logic [1:0] ed, input logic [4:0] ep);
        n_cmp++;
        if ({target_valid, target_floor, dir, pending} !== {etv, etf, ed, ep}) begin
            n_fail++;
            $display("FAIL %s: got tv=%0b tf=%0d dir=%b pend=%b, want tv=%0b tf=%0d dir=%b pend=%b",
                     nm, target_valid, target_floor, dir, pending, etv, etf, ed, ep);
        end
    endtask

    initial begin
        logic [2:0] cur_r;
        logic [4:0] rq;
        logic       ar;
        logic       rs;
        int         r;

        // Basic request/serve/idle flow, then the equal-distance tie and reversal.
        vecs[0]  = mk(1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00000);
        vecs[1]  = mk(1'b1, 5'b00100, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00100);
        vecs[2]  = mk(1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00100);
        vecs[3]  = mk(1'b1, 5'b00000, 3'd0, 1'b0, 1'b1, 3'd2, 2'b01, 5'b00100);
        vecs[4]  = mk(1'b1, 5'b00000, 3'd1, 1'b0, 1'b1, 3'd2, 2'b01, 5'b00100);
        vecs[5]  = mk(1'b1, 5'b00000, 3'd2, 1'b1, 1'b0, 3'd2, 2'b01, 5'b00000);
        vecs[6]  = mk(1'b1, 5'b00000, 3'd2, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000);
        vecs[7]  = mk(1'b1, 5'b00000, 3'd2, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000);
        vecs[8]  = mk(1'b1, 5'b10001, 3'd2, 1'b0, 1'b0, 3'd2, 2'b00, 5'b10001);
        vecs[9]  = mk(1'b1, 5'b00000, 3'd2, 1'b0, 1'b0, 3'd2, 2'b00, 5'b10001);
        vecs[10] = mk(1'b1, 5'b00000, 3'd2, 1'b0, 1'b1, 3'd4, 2'b01, 5'b10001);
        vecs[11] = mk(1'b1, 5'b00000, 3'd3, 1'b0, 1'b1, 3'd4, 2'b01, 5'b10001);
        vecs[12] = mk(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 3'd4, 2'b01, 5'b00001);
        vecs[13] = mk(1'b1, 5'b00000, 3'd4, 1'b0, 1'b1, 3'd0, 2'b10, 5'b00001);
        vecs[14] = mk(1'b1, 5'b00000, 3'd3, 1'b0, 1'b1, 3'd0, 2'b10, 5'b00001);
        vecs[15] = mk(1'b1, 5'b00000, 3'd0, 1'b1, 1'b0, 3'd0, 2'b10, 5'b00000);
        vecs[16] = mk(1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00000);

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].req, vecs[i].cur, vecs[i].arr, vecs[i].rst);
            check($sformatf("vec%0d", i), vecs[i].tv, vecs[i].tf, vecs[i].dir, vecs[i].pend);
        end

        // Retarget en route, no retarget for the current floor, ignored mismatched arrival.
        apply(5'b10000, 3'd0, 1'b0, 1'b1);
        apply(5'b00000, 3'd0, 1'b0, 1'b1);
        apply(5'b00000, 3'd1, 1'b0, 1'b1);
        check("sel_up", 1'b1, 3'd4, 2'b01, 5'b10000);
        apply(5'b01000, 3'd1, 1'b0, 1'b1);
        check("req3_latched", 1'b1, 3'd4, 2'b01, 5'b11000);
        apply(5'b00000, 3'd1, 1'b0, 1'b1);
        check("retarget3", 1'b1, 3'd3, 2'b01, 5'b11000);
        apply(5'b00010, 3'd1, 1'b0, 1'b1);
        apply(5'b00000, 3'd1, 1'b0, 1'b1);
        check("no_retarget_cur", 1'b1, 3'd3, 2'b01, 5'b11010);
        apply(5'b00000, 3'd1, 1'b1, 1'b1);
        check("arr_mismatch", 1'b1, 3'd3, 2'b01, 5'b11010);

        // Arrival clear beats a same-cycle request at that floor; other bits still latch.
        apply(5'b01001, 3'd3, 1'b1, 1'b1);
        check("clear_wins", 1'b0, 3'd3, 2'b01, 5'b10011);
        apply(5'b00000, 3'd3, 1'b0, 1'b1);
        check("resel_up", 1'b1, 3'd4, 2'b01, 5'b10011);

        // Reset mid-serve drops everything; arrival while idle changes nothing.
        apply(5'b00000, 3'd3, 1'b0, 1'b0);
        check("reset_mid", 1'b0, 3'd0, 2'b00, 5'b00000);
        apply(5'b00000, 3'd3, 1'b1, 1'b1);
        check("arr_idle", 1'b0, 3'd0, 2'b00, 5'b00000);

        // Invalid cur_floor holds SELECT until a valid floor shows up.
        apply(5'b00100, 3'd7, 1'b0, 1'b1);
        apply(5'b00000, 3'd7, 1'b0, 1'b1);
        apply(5'b00000, 3'd7, 1'b0, 1'b1);
        check("sel_invalid7", 1'b0, 3'd0, 2'b00, 5'b00100);
        apply(5'b00000, 3'd5, 1'b0, 1'b1);
        check("sel_invalid5", 1'b0, 3'd0, 2'b00, 5'b00100);
        apply(5'b00000, 3'd1, 1'b0, 1'b1);
        check("sel_valid", 1'b1, 3'd2, 2'b01, 5'b00100);

        // Random traffic: car drifts toward the model's target, occasional resets and bad floors.
        apply(5'b00000, 3'd0, 1'b0, 1'b0);
        cur_r = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            rq = 5'b00000;
            if ($urandom_range(0, 5) == 0) rq = 5'($urandom_range(1, 31));
            rs = ($urandom_range(0, 299) != 0);
            r = int'($urandom_range(0, 9));
            if (r == 0) cur_r = 3'($urandom_range(5, 7));
            else if (cur_r > 3'd4) cur_r = 3'($urandom_range(0, 4));
            else if (r < 5 && m_tv) begin
                if (int'(cur_r) < m_tf) cur_r = cur_r + 3'd1;
                else if (int'(cur_r) > m_tf) cur_r = cur_r - 3'd1;
            end
            else if (r == 5 && cur_r < 3'd4) cur_r = cur_r + 3'd1;
            else if (r == 6 && cur_r > 3'd0) cur_r = cur_r - 3'd1;
            if (m_tv && int'(cur_r) == m_tf) ar = ($urandom_range(0, 1) == 1);
            else ar = ($urandom_range(0, 15) == 0);
            apply(rq, cur_r, ar, rs);
            check($sformatf("rand%0d", i), m_tv, 3'(m_tf), 2'(m_dir), m_pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
